// File: rtl/clk_int_div_mch.sv
// Multi-channel programmable integer clock divider: clk_o[c] = clk_i / (div+1), glitch-free updates.
// Optional macro CLK_INT_DIV_MCH_BYPASS_EN: div==0 in RUN passes clk_i straight through.
module clk_int_div_mch #(
  parameter int CHANNELS    = 4,
  parameter int DIV_WIDTH   = 8,
  parameter int RST_DIV     = 1,
  parameter int DONE_CYCLES = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [CHANNELS-1:0]           en_i,
  input  logic                          sync_i,
  input  logic [CHANNELS*DIV_WIDTH-1:0] div_i,
  input  logic [CHANNELS-1:0]           div_valid_i,
  output logic [CHANNELS-1:0]           div_ready_o,
  output logic [CHANNELS-1:0]           div_done_o,
  output logic [CHANNELS-1:0]           active_o,
  output logic [CHANNELS-1:0]           clk_o
);

  localparam int DW = DIV_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

`ifdef CLK_INT_DIV_MCH_BYPASS_EN
  localparam logic [DW-1:0] RST_DIV_EFF = DW'(RST_DIV);
`else
  localparam logic [DW-1:0] RST_DIV_EFF = (RST_DIV == 0) ? DW'(1) : DW'(RST_DIV);
`endif
  localparam logic [2:0] DONE_CNT = 3'(DONE_CYCLES);

  state_e                       state_q [CHANNELS];
  state_e                       state_d [CHANNELS];
  logic [CHANNELS-1:0][DW-1:0]  cnt_q, cnt_d;
  logic [CHANNELS-1:0][DW-1:0]  div_act_q, div_act_d;
  logic [CHANNELS-1:0][DW-1:0]  shadow_q, shadow_d;
  logic [CHANNELS-1:0][2:0]     done_cnt_q, done_cnt_d;
  logic [CHANNELS-1:0]          pending_q, pending_d;
  logic [CHANNELS-1:0]          clk_q, clk_d;

  logic [CHANNELS-1:0]          running;
  logic [CHANNELS-1:0]          boundary;
  logic [CHANNELS-1:0]          accept;
  logic [CHANNELS-1:0]          apply;

  function automatic logic [DW-1:0] clamp_div(input logic [DW-1:0] v);
`ifdef CLK_INT_DIV_MCH_BYPASS_EN
    return v;
`else
    return (v == '0) ? DW'(1) : v;
`endif
  endfunction

  // High for the first ceil(N/2) counts of a period, which reduces to cnt <= div/2.
  function automatic logic high_phase(input logic [DW-1:0] cnt, input logic [DW-1:0] div);
    return cnt <= (div >> 1);
  endfunction

  always_comb begin
    running  = '0;
    boundary = '0;
    accept   = '0;
    apply    = '0;
    clk_d    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c]    = state_q[c];
      cnt_d[c]      = cnt_q[c];
      div_act_d[c]  = div_act_q[c];
      shadow_d[c]   = shadow_q[c];
      pending_d[c]  = pending_q[c];
      done_cnt_d[c] = done_cnt_q[c];

      running[c]  = (state_q[c] != IDLE);
      boundary[c] = running[c] && (cnt_q[c] == div_act_q[c]);
      accept[c]   = div_valid_i[c] && !pending_q[c];
      apply[c]    = pending_q[c] && (!running[c] || boundary[c] || sync_i);

      unique case (state_q[c])
        IDLE:    if (en_i[c]) state_d[c] = RUN;
        RUN:     if (!en_i[c]) state_d[c] = boundary[c] ? IDLE : DRAIN;
        DRAIN: begin
          if (en_i[c])         state_d[c] = RUN;
          else if (boundary[c]) state_d[c] = IDLE;
        end
        default: state_d[c] = IDLE;
      endcase

      if (running[c] && !boundary[c] && !sync_i) cnt_d[c] = cnt_q[c] + DW'(1);
      else                                       cnt_d[c] = '0;

      if (boundary[c] && (done_cnt_q[c] < DONE_CNT)) done_cnt_d[c] = done_cnt_q[c] + 3'd1;

      // Apply and accept are mutually exclusive because they key off opposite pending states.
      if (apply[c]) begin
        div_act_d[c]  = shadow_q[c];
        cnt_d[c]      = '0;
        pending_d[c]  = 1'b0;
        done_cnt_d[c] = '0;
      end
      if (accept[c]) begin
        shadow_d[c]   = clamp_div(div_i[c*DW +: DW]);
        pending_d[c]  = 1'b1;
        done_cnt_d[c] = '0;
      end

      clk_d[c] = (state_d[c] != IDLE) && high_phase(cnt_d[c], div_act_d[c]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < CHANNELS; c++) state_q[c] <= IDLE;
      cnt_q      <= '0;
      div_act_q  <= {CHANNELS{RST_DIV_EFF}};
      shadow_q   <= {CHANNELS{RST_DIV_EFF}};
      done_cnt_q <= '0;
      pending_q  <= '0;
      clk_q      <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) state_q[c] <= state_d[c];
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      shadow_q   <= shadow_d;
      done_cnt_q <= done_cnt_d;
      pending_q  <= pending_d;
      clk_q      <= clk_d;
    end
  end

  always_comb begin
    div_ready_o = ~pending_q;
    div_done_o  = '0;
    active_o    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      div_done_o[c] = (done_cnt_q[c] == DONE_CNT);
      active_o[c]   = (state_q[c] != IDLE);
    end
  end

`ifdef CLK_INT_DIV_MCH_BYPASS_EN
  // Divide-by-1 cannot come from a flop, so the source clock is muxed out directly.
  always_comb begin
    clk_o = clk_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if ((state_q[c] == RUN) && (div_act_q[c] == '0)) clk_o[c] = clk_i;
    end
  end
`else
  assign clk_o = clk_q;
`endif

endmodule
